// File: rtl/muldiv_pkg.sv
// muldiv_pkg: ALU control codes, FSM state encoding and counter sizing for muldiv_sequencer.
package muldiv_pkg;
  localparam logic [5:0] MULT = 6'b001000;
  localparam logic [5:0] DIV  = 6'b001010;
  localparam logic [5:0] MFHI = 6'b001111;
  localparam logic [5:0] MFLO = 6'b000001;
  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DZERO, ST_FIX} state_t;
  function automatic int cnt_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add multiply or restoring-divide iteration on a 2*WIDTH register.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [WIDTH:0] w_sum, w_trial;
  assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_m} : '0);
  // Trial subtract on the remainder after its left shift; bit WIDTH is the borrow.
  assign w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_m};
  always_comb
    o_acc = !i_div ? {w_sum, i_acc[WIDTH-1:1]} :
            w_trial[WIDTH] ? {i_acc[2*WIDTH-2:0], 1'b0} :
            {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative mult/div sequencer owning HI/LO, serving mfhi/mflo and stalling while busy.
// MULDIV_SIGNED_EN selects two's-complement mult/div with an extra sign-fix cycle.
module muldiv_sequencer import muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);
  localparam int CW = cnt_w(WIDTH);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_step;
  logic [WIDTH-1:0] r_m, r_hi, r_lo, w_a, w_b;
  logic r_done, w_mul, w_div, w_known;
`ifdef MULDIV_SIGNED_EN
  localparam state_t ST_AFTER = ST_FIX;
  logic r_sa, r_sq, r_isdiv;
  assign w_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_b = op_b[WIDTH-1] ? -op_b : op_b;
`else
  localparam state_t ST_AFTER = ST_IDLE;
  assign w_a = op_a;
  assign w_b = op_b;
`endif
  assign w_mul   = start && alu_ctrl == MULT;
  assign w_div   = start && alu_ctrl == DIV;
  assign w_known = alu_ctrl == MULT || alu_ctrl == DIV || alu_ctrl == MFHI || alu_ctrl == MFLO;
  assign busy    = r_state != ST_IDLE;
  assign stall   = start && w_known && busy;
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rd_data = alu_ctrl == MFHI ? r_hi : alu_ctrl == MFLO ? r_lo : '0;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div(r_state == ST_DIV),
    .i_acc(r_acc),
    .i_m(r_m),
    .o_acc(w_step)
  );
  always_ff @(posedge clk)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:        w_next = w_mul ? ST_MUL : !w_div ? ST_IDLE : op_b == '0 ? ST_DZERO : ST_DIV;
      ST_MUL, ST_DIV: w_next = r_cnt != '0 ? r_state : ST_AFTER;
      default:        w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_m    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_mul || w_div) begin
          r_cnt <= CW'(WIDTH - 1);
          r_m   <= w_mul ? w_a : w_b;
          // A zero divisor keeps the raw dividend so DZERO can return it as HI.
          r_acc <= {{WIDTH{1'b0}}, w_mul ? w_b : op_b == '0 ? op_a : w_a};
`ifdef MULDIV_SIGNED_EN
          r_sa    <= op_a[WIDTH-1];
          r_sq    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
          r_isdiv <= w_div;
`endif
        end
        ST_MUL, ST_DIV: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - 1'b1;
`ifndef MULDIV_SIGNED_EN
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_step;
            r_done       <= 1'b1;
          end
`endif
        end
        ST_DZERO: begin
          r_hi   <= r_acc[WIDTH-1:0];
          r_lo   <= '1;
          r_done <= 1'b1;
        end
`ifdef MULDIV_SIGNED_EN
        ST_FIX: begin
          if (r_isdiv) begin
            r_hi <= r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_sq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
          end else {r_hi, r_lo} <= r_sq ? -r_acc : r_acc;
          r_done <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer (honours MULDIV_SIGNED_EN).
module tb_muldiv_sequencer;
  localparam logic [5:0] C_MULT = 6'b001000, C_DIV = 6'b001010, C_MFHI = 6'b001111, C_MFLO = 6'b000001;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif
  logic clk = 0, rst_n = 0, start = 0;
  logic [5:0] alu_ctrl = 6'b0;
  logic [31:0] op_a = 0, op_b = 0;
  logic busy, done, stall;
  logic [31:0] hi, lo, rd_data;
  int checks = 0, failures = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1; alu_ctrl = c; op_a = a; op_b = b;
    @(negedge clk);
    start = 0; alu_ctrl = 6'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
  endtask

  task automatic test_mult_small;
    int n;
    issue(C_MULT, 32'd7, 32'd6);
    wait_idle(n);
    checks++; if (n != LAT) begin failures++; $display("FAIL mul7x6_cycles: got %0d want %0d", n, LAT); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mul7x6_done: got %b want 1", done); end
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL mul7x6_lo: got %h want 2a", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL mul7x6_hi: got %h want 0", hi); end
    alu_ctrl = C_MFLO;
    #1;
    checks++; if (rd_data !== 32'd42) begin failures++; $display("FAIL mflo_rd: got %h want 2a", rd_data); end
    @(negedge clk);
    alu_ctrl = 6'b0;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_mult_max;
    int n;
    logic [63:0] exp;
`ifdef MULDIV_SIGNED_EN
    exp = 64'h0000_0000_0000_0001;
`else
    exp = 64'hFFFF_FFFE_0000_0001;
`endif
    issue(C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if ({hi, lo} !== exp) begin failures++; $display("FAIL mul_max: got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_div;
    int n;
    issue(C_DIV, 32'd100, 32'd7);
    wait_idle(n);
    checks++; if (n != LAT) begin failures++; $display("FAIL div_cycles: got %0d want %0d", n, LAT); end
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL div100_7: got %h want 000000020000000e", {hi, lo}); end
    issue(C_DIV, 32'd5, 32'd0);
    wait_idle(n);
    checks++; if (n != 1) begin failures++; $display("FAIL dzero_cycles: got %0d want 1", n); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL dzero_done: got %b want 1", done); end
    checks++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin failures++; $display("FAIL dzero_hilo: got %h want 00000005ffffffff", {hi, lo}); end
  endtask

  task automatic test_stall;
    int n;
    issue(C_MULT, 32'h0001_0000, 32'h0003_0000);
    repeat (4) @(negedge clk);
    start = 1; alu_ctrl = C_MFHI;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_mfhi: got %b want 1", stall); end
    @(negedge clk);
    alu_ctrl = C_MULT; op_a = 32'd9; op_b = 32'd9;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_mult: got %b want 1", stall); end
    @(negedge clk);
    start = 0; alu_ctrl = 6'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_nostart: got %b want 0", stall); end
    wait_idle(n);
    checks++; if (n + 6 != LAT) begin failures++; $display("FAIL stall_cycles: got %0d want %0d", n + 6, LAT); end
    checks++; if ({hi, lo} !== 64'h0000_0003_0000_0000) begin failures++; $display("FAIL stall_hilo: got %h want 0000000300000000", {hi, lo}); end
    start = 1; alu_ctrl = C_MFHI;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_idle: got %b want 0", stall); end
    checks++; if (rd_data !== 32'd3) begin failures++; $display("FAIL mfhi_new: got %h want 3", rd_data); end
    @(negedge clk);
    start = 0; alu_ctrl = 6'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL not_queued: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(C_MULT, 32'd7, 32'd6);
    wait_idle(n);
    start = 1; alu_ctrl = C_DIV; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 0; alu_ctrl = 6'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got %b want 1", busy); end
    wait_idle(n);
    checks++; if (n != LAT) begin failures++; $display("FAIL b2b_cycles: got %0d want %0d", n, LAT); end
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("FAIL b2b_hilo: got %h want 000000020000000e", {hi, lo}); end
  endtask

  task automatic test_reset_abort;
    int dones = 0, busies = 0;
    issue(C_MULT, 32'd7, 32'd6);
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL abort_hilo: got %h want 0", {hi, lo}); end
    for (int i = 0; i < 40; i++) begin
      dones += int'(done);
      busies += int'(busy);
      @(negedge clk);
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
    checks++; if (busies != 0) begin failures++; $display("FAIL abort_resume: got %0d busy cycles want 0", busies); end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed;
    int n;
    issue(C_MULT, -32'sd6, 32'sd7);
    wait_idle(n);
    checks++; if (n != 33) begin failures++; $display("FAIL smul_cycles: got %0d want 33", n); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFD6) begin failures++; $display("FAIL smul: got %h want ffffffffffffffd6", {hi, lo}); end
    issue(C_DIV, -32'sd7, 32'sd2);
    wait_idle(n);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL sdiv: got %h want fffffffffffffffd", {hi, lo}); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_mult_small;
    test_mult_max;
    test_div;
    test_stall;
    test_back_to_back;
    test_reset_abort;
`ifdef MULDIV_SIGNED_EN
    test_signed;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
